// File: rtl/ir_capture.sv
// Interrupt-request front end: synchronise, debounce, latch pending edges, pick the top unmasked request.
// Build macro IR_DEBOUNCE_EN enables the per-line debounce counters; without it, lines only pass through the synchroniser.

module ir_capture_line
`ifdef IR_DEBOUNCE_EN
#(
    parameter int DEB_LIMIT = 500000,
    parameter int DEB_W     = 20
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic ack_hit,
    input  logic clr_lost,
    output logic pend,
    output logic lost
);
    logic s1, s2, stable, rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

`ifdef IR_DEBOUNCE_EN
    logic [DEB_W-1:0] cnt;
    logic             done;

    // done marks the DEB_LIMIT-th consecutive cycle that s2 differs from stable
    assign done = (cnt == DEB_W'(DEB_LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (s2 == stable) begin
            cnt <= '0;
        end else if (done) begin
            stable <= s2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign rise = done & s2 & ~stable;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stable <= 1'b0;
        else        stable <= s2;
    end

    assign rise = s2 & ~stable;
`endif

    // a new edge beats a same-cycle ack, so the request is never dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
            lost <= 1'b0;
        end else begin
            if (rise)         pend <= 1'b1;
            else if (ack_hit) pend <= 1'b0;

            if (rise && pend && !ack_hit) lost <= 1'b1;
            else if (clr_lost)            lost <= 1'b0;
        end
    end
endmodule

module ir_capture #(
    parameter int NUM_IR    = 4,
    parameter int ID_W      = 2,
    parameter int DEB_LIMIT = 500000,
    parameter int DEB_W     = 20
) (
    input  logic              clk,
    input  logic              in_RST,
    input  logic [NUM_IR-1:0] raw_IR,
    input  logic [NUM_IR-1:0] mask,
    input  logic              ack,
    input  logic [ID_W-1:0]   ack_id,
    input  logic              clr_lost,
    output logic [NUM_IR-1:0] pend,
    output logic              req,
    output logic [ID_W-1:0]   req_id,
    output logic [NUM_IR-1:0] lost
);
    logic [NUM_IR-1:0] hit;
    logic [NUM_IR-1:0] act;

    generate
        if (NUM_IR < 2 || NUM_IR > 8 || (1 << ID_W) < NUM_IR ||
            DEB_LIMIT < 2 || (DEB_LIMIT - 1) >= (1 << DEB_W)) begin : g_bad_param
            $error("ir_capture: parameter set out of range");
        end
    endgenerate

    // ids at or beyond NUM_IR match no line and are ignored
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_IR; i++)
            hit[i] = ack && (ack_id == ID_W'(i));
    end

    ir_capture_line
`ifdef IR_DEBOUNCE_EN
    #(
        .DEB_LIMIT (DEB_LIMIT),
        .DEB_W     (DEB_W)
    )
`endif
    u_line [NUM_IR-1:0] (
        .clk      (clk),
        .rst_n    (in_RST),
        .raw      (raw_IR),
        .ack_hit  (hit),
        .clr_lost (clr_lost),
        .pend     (pend),
        .lost     (lost)
    );

    assign act = pend & ~mask;
    assign req = |act;

    // ascending scan so the highest active index is the one left standing
    always_comb begin
        req_id = '0;
        for (int i = 0; i < NUM_IR; i++)
            if (act[i]) req_id = ID_W'(i);
    end
endmodule

// File: tb/tb_ir_capture.sv
// Bench for ir_capture: directed scenarios plus randomized traffic against a behavioural model.
// Expected latencies follow IR_DEBOUNCE_EN the same way the design does.

module tb_ir_capture;
    localparam int DL = 4;
`ifdef IR_DEBOUNCE_EN
    localparam int LAT    = DL + 2;
    localparam bit DEB_ON = 1'b1;
`else
    localparam int LAT    = 3;
    localparam bit DEB_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       in_RST = 1'b0;
    logic [3:0] raw_IR = '0;
    logic [3:0] mask = '0;
    logic       ack = 1'b0;
    logic [1:0] ack_id = '0;
    logic       clr_lost = 1'b0;
    logic [3:0] pend, lost;
    logic       req;
    logic [1:0] req_id;
    logic [2:0] pend3, lost3;
    logic       req3;
    logic [1:0] req_id3;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    ir_capture #(.NUM_IR(4), .ID_W(2), .DEB_LIMIT(DL), .DEB_W(3)) dut (
        .clk(clk), .in_RST(in_RST), .raw_IR(raw_IR), .mask(mask), .ack(ack),
        .ack_id(ack_id), .clr_lost(clr_lost), .pend(pend), .req(req),
        .req_id(req_id), .lost(lost)
    );

    ir_capture #(.NUM_IR(3), .ID_W(2), .DEB_LIMIT(DL), .DEB_W(3)) dut3 (
        .clk(clk), .in_RST(in_RST), .raw_IR(raw_IR[2:0]), .mask(mask[2:0]), .ack(ack),
        .ack_id(ack_id), .clr_lost(clr_lost), .pend(pend3), .req(req3),
        .req_id(req_id3), .lost(lost3)
    );

    // Reference model: raw is seen two edges late; a level is accepted once it has
    // disagreed with the accepted level for DL samples in a row.
    logic [3:0] m_q1 = '0, m_q2 = '0, m_stable = '0, m_pend = '0, m_lost = '0;
    int         m_run [4] = '{0, 0, 0, 0};

    always @(posedge clk or negedge in_RST) begin
        if (!in_RST) begin
            m_q1 = '0; m_q2 = '0; m_stable = '0; m_pend = '0; m_lost = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin : mline
                bit smp, rise, hit, was;
                smp  = m_q2[i];
                rise = 1'b0;
`ifdef IR_DEBOUNCE_EN
                m_run[i] = (smp != m_stable[i]) ? m_run[i] + 1 : 0;
                if (m_run[i] == DL) begin
                    rise        = smp;
                    m_stable[i] = smp;
                    m_run[i]    = 0;
                end
`else
                rise        = smp & ~m_stable[i];
                m_stable[i] = smp;
`endif
                hit = ack && (ack_id == 2'(i));
                was = m_pend[i];
                if (rise)     m_pend[i] = 1'b1;
                else if (hit) m_pend[i] = 1'b0;
                if (rise && was && !hit) m_lost[i] = 1'b1;
                else if (clr_lost)       m_lost[i] = 1'b0;
            end
            m_q2 = m_q1;
            m_q1 = raw_IR;
        end
    end

    function automatic logic [1:0] top_id(input logic [3:0] v);
        top_id = 2'd0;
        for (int i = 0; i < 4; i++) if (v[i]) top_id = 2'(i);
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        raw_IR = '0;
        mask   = '0;
        repeat (LAT + 2) tick();
        for (int i = 0; i < 4; i++) begin
            if (m_pend[i]) begin
                ack = 1'b1; ack_id = 2'(i);
                tick();
                ack = 1'b0;
            end
        end
        clr_lost = 1'b1;
        tick();
        clr_lost = 1'b0;
        vectors++;
        if (pend !== 4'b0000 || lost !== 4'b0000) begin
            errors++;
            $display("FAIL settle: pend=%b lost=%b, want 0000 0000", pend, lost);
        end
    endtask

    task automatic test_reset();
        in_RST = 1'b0;
        repeat (3) tick();
        vectors++; if (pend !== 4'b0000) begin errors++; $display("FAIL reset_pend: got %b want 0000", pend); end
        vectors++; if (lost !== 4'b0000) begin errors++; $display("FAIL reset_lost: got %b want 0000", lost); end
        vectors++; if (req !== 1'b0 || req_id !== 2'd0) begin errors++; $display("FAIL reset_req: got %b/%0d want 0/0", req, req_id); end
        in_RST = 1'b1;
    endtask

    task automatic test_latency();
        raw_IR = 4'b0100;
        for (int e = 1; e <= LAT; e++) begin
            tick();
            vectors++;
            if (pend !== ((e == LAT) ? 4'b0100 : 4'b0000)) begin
                errors++;
                $display("FAIL latency_pend edge %0d: got %b want %b", e, pend, (e == LAT) ? 4'b0100 : 4'b0000);
            end
        end
        vectors++; if (req !== 1'b1 || req_id !== 2'd2) begin errors++; $display("FAIL latency_req: got %b/%0d want 1/2", req, req_id); end
        vectors++; if (lost !== 4'b0000) begin errors++; $display("FAIL latency_lost: got %b want 0000", lost); end
        settle();
    endtask

    task automatic test_glitch();
        raw_IR[0] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            vectors++;
            if (pend[0] !== (!DEB_ON && e >= 3)) begin
                errors++;
                $display("FAIL glitch3 edge %0d: pend[0]=%b want %b", e, pend[0], (!DEB_ON && e >= 3));
            end
            if (e == 3) raw_IR[0] = 1'b0;
        end
        settle();
        raw_IR[0] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            vectors++;
            if (pend[0] !== (e >= LAT)) begin
                errors++;
                $display("FAIL pulse4 edge %0d: pend[0]=%b want %b", e, pend[0], (e >= LAT));
            end
            if (e == 4) raw_IR[0] = 1'b0;
        end
        settle();
    endtask

    task automatic test_priority_mask();
        raw_IR = 4'b1010;
        repeat (LAT) tick();
        vectors++; if (pend !== 4'b1010) begin errors++; $display("FAIL prio_pend: got %b want 1010", pend); end
        vectors++; if (req !== 1'b1 || req_id !== 2'd3) begin errors++; $display("FAIL prio_id: got %b/%0d want 1/3", req, req_id); end
        mask = 4'b1000;
        #1;
        vectors++; if (req !== 1'b1 || req_id !== 2'd1) begin errors++; $display("FAIL mask_id: got %b/%0d want 1/1", req, req_id); end
        ack = 1'b1; ack_id = 2'd1;
        tick();
        ack = 1'b0;
        vectors++; if (pend !== 4'b1000 || req !== 1'b0 || req_id !== 2'd0) begin
            errors++; $display("FAIL ack1: pend=%b req=%b id=%0d want 1000 0 0", pend, req, req_id);
        end
        mask = 4'b0000;
        #1;
        vectors++; if (req !== 1'b1 || req_id !== 2'd3) begin errors++; $display("FAIL unmask_id: got %b/%0d want 1/3", req, req_id); end
        settle();
    endtask

    task automatic test_lost();
        raw_IR = 4'b0100;
        repeat (LAT) tick();
        vectors++; if (pend !== 4'b0100 || lost !== 4'b0000) begin errors++; $display("FAIL lost_setup: pend=%b lost=%b want 0100 0000", pend, lost); end
        raw_IR = 4'b0000;
        repeat (LAT + 1) tick();
        raw_IR = 4'b0100;
        repeat (LAT) tick();
        vectors++; if (lost !== 4'b0100 || pend !== 4'b0100) begin errors++; $display("FAIL lost_set: lost=%b pend=%b want 0100 0100", lost, pend); end
        vectors++; if (lost3 !== 3'b100) begin errors++; $display("FAIL lost_set3: got %b want 100", lost3); end
        clr_lost = 1'b1;
        tick();
        clr_lost = 1'b0;
        vectors++; if (lost !== 4'b0000) begin errors++; $display("FAIL clr_lost: got %b want 0000", lost); end
        raw_IR = 4'b0000;
        repeat (LAT + 1) tick();
        raw_IR = 4'b0100;
        repeat (LAT - 1) tick();
        ack = 1'b1; ack_id = 2'd2;
        tick();
        ack = 1'b0;
        vectors++; if (pend !== 4'b0100 || lost !== 4'b0000) begin errors++; $display("FAIL rise_vs_ack: pend=%b lost=%b want 0100 0000", pend, lost); end
        settle();
    endtask

    task automatic test_bad_ack();
        raw_IR = 4'b0100;
        repeat (LAT) tick();
        ack = 1'b1; ack_id = 2'd0;
        tick();
        ack = 1'b0;
        vectors++; if (pend !== 4'b0100 || lost !== 4'b0000) begin errors++; $display("FAIL ack_nonpend: pend=%b lost=%b want 0100 0000", pend, lost); end
        raw_IR = 4'b0111;
        repeat (LAT) tick();
        vectors++; if (pend3 !== 3'b111) begin errors++; $display("FAIL bad_ack_setup3: got %b want 111", pend3); end
        ack = 1'b1; ack_id = 2'd3;
        tick();
        ack = 1'b0;
        vectors++; if (pend3 !== 3'b111 || lost3 !== 3'b000) begin errors++; $display("FAIL ack_out_of_range: pend3=%b lost3=%b want 111 000", pend3, lost3); end
        vectors++; if (pend !== 4'b0111) begin errors++; $display("FAIL ack_id3_nonpend: got %b want 0111", pend); end
        settle();
    endtask

    task automatic test_async_reset();
        raw_IR = 4'b1111;
        repeat (LAT) tick();
        raw_IR = 4'b1100;
        repeat (LAT + 1) tick();
        raw_IR = 4'b1111;
        repeat (LAT) tick();
        vectors++; if (pend !== 4'b1111 || lost !== 4'b0011) begin errors++; $display("FAIL arst_setup: pend=%b lost=%b want 1111 0011", pend, lost); end
        #2 in_RST = 1'b0;
        #1;
        vectors++; if (pend !== 4'b0000 || lost !== 4'b0000 || req !== 1'b0 || req_id !== 2'd0) begin
            errors++; $display("FAIL arst_immediate: pend=%b lost=%b req=%b id=%0d want all 0", pend, lost, req, req_id);
        end
        raw_IR = 4'b0000;
        tick();
        in_RST = 1'b1;
        raw_IR = 4'b0010;
        repeat (4) tick();
        #2 in_RST = 1'b0;
        #1;
        vectors++; if (pend !== 4'b0000) begin errors++; $display("FAIL arst_partial: got %b want 0000", pend); end
        tick();
        in_RST = 1'b1;
        for (int e = 1; e <= LAT; e++) begin
            tick();
            vectors++;
            if (pend[1] !== (e == LAT)) begin
                errors++; $display("FAIL arst_recount edge %0d: pend[1]=%b want %b", e, pend[1], (e == LAT));
            end
        end
        settle();
    endtask

    task automatic test_short_pulse();
        raw_IR[1] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 1) raw_IR[1] = 1'b0;
            vectors++;
            if (pend[1] !== (!DEB_ON && e >= 3)) begin
                errors++; $display("FAIL pulse1 edge %0d: pend[1]=%b want %b", e, pend[1], (!DEB_ON && e >= 3));
            end
        end
        settle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            tick();
            vectors++;
            if (pend !== m_pend || lost !== m_lost) begin
                errors++; $display("FAIL rnd_state cyc %0d: pend=%b lost=%b want %b %b", c, pend, lost, m_pend, m_lost);
            end
            vectors++;
            if (req !== |(m_pend & ~mask) || req_id !== top_id(m_pend & ~mask)) begin
                errors++; $display("FAIL rnd_req cyc %0d: %b/%0d want %b/%0d", c, req, req_id, |(m_pend & ~mask), top_id(m_pend & ~mask));
            end
            vectors++;
            if (pend3 !== m_pend[2:0] || lost3 !== m_lost[2:0] || req3 !== |(m_pend[2:0] & ~mask[2:0]) ||
                req_id3 !== top_id({1'b0, m_pend[2:0] & ~mask[2:0]})) begin
                errors++; $display("FAIL rnd_n3 cyc %0d: pend3=%b lost3=%b req3=%b id3=%0d", c, pend3, lost3, req3, req_id3);
            end
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 5) == 0) raw_IR[i] = ~raw_IR[i];
            if ($urandom_range(0, 7) == 0) mask = 4'($urandom);
            ack      = ($urandom_range(0, 3) == 0);
            ack_id   = 2'($urandom);
            clr_lost = ($urandom_range(0, 15) == 0);
        end
        ack = 1'b0;
        clr_lost = 1'b0;
        settle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_priority_mask();
        test_lost();
        test_bad_ack();
        test_async_reset();
        test_short_pulse();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
